// File: rtl/tdec_t_b.sv
// Temporal decoder: per channel, the phase of the first rising input in each gamma cycle.
// Result is registered 1 edge after the gamma ends; a result arriving while the previous one is still held is dropped and flagged on overrun.
module tdec_t_b #(
   parameter int NUM_INPUTS        = 4,
   parameter int GAMMA_CYCLE_WIDTH = 16,
   localparam int TW = $clog2(GAMMA_CYCLE_WIDTH + 1),
   localparam int PW = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic                     clk,
   input  logic                     grst,
   input  logic                     en,
   input  logic [NUM_INPUTS-1:0]    inputs,
   output logic [NUM_INPUTS*TW-1:0] out_times,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     overrun
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [TW-1:0] T_INF  = TW'(GAMMA_CYCLE_WIDTH);
   localparam logic [TW-1:0] T_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [PW-1:0] PH_END = PW'(GAMMA_CYCLE_WIDTH - 1);

   state_t                  state;
   logic [PW-1:0]           ph;
   logic [TW-1:0]           cap [NUM_INPUTS];
   logic [NUM_INPUTS-1:0]   got;
   logic [NUM_INPUTS*TW-1:0] fin;
   logic                    last;

   assign last = (state == RUN) && en && (ph == PH_END);

   // The ph=G-1 sample is folded in here so it lands in this cycle's result.
   always_comb begin
      fin = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (got[i])
            fin[i*TW +: TW] = cap[i];
         else if (inputs[i])
            fin[i*TW +: TW] = T_LAST;
         else
            fin[i*TW +: TW] = T_INF;
      end
   end

   always_ff @(posedge clk or posedge grst) begin
      if (grst) begin
         state     <= IDLE;
         ph        <= '0;
         got       <= '0;
         for (int i = 0; i < NUM_INPUTS; i++)
            cap[i] <= T_INF;
         out_times <= {NUM_INPUTS{T_INF}};
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (state == RUN && en && !last) begin
            ph <= ph + 1'b1;
            for (int i = 0; i < NUM_INPUTS; i++) begin
               if (inputs[i] && !got[i]) begin
                  cap[i] <= TW'(ph);
                  got[i] <= 1'b1;
               end
            end
         end else begin
            // Idle, abort, or gamma end: start the next gamma from a clean slate.
            ph  <= '0;
            got <= '0;
            for (int i = 0; i < NUM_INPUTS; i++)
               cap[i] <= T_INF;
         end

         case (state)
            IDLE:    if (en)  state <= RUN;
            RUN:     if (!en) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (last) begin
            if (!out_valid || out_ready) begin
               out_times <= fin;
               out_valid <= 1'b1;
            end else begin
               overrun   <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tdec_t_b.sv
// Bench for tdec_t_b: directed gamma scenarios plus random traffic against a sample-history reference model.
module tb_tdec_t_b;
   localparam int N  = 4;
   localparam int G  = 16;
   localparam int TW = 5;

   logic            clk = 1'b0;
   logic            grst;
   logic            en;
   logic [N-1:0]    inputs;
   logic [N*TW-1:0] out_times;
   logic            out_valid;
   logic            out_ready;
   logic            overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tdec_t_b #(.NUM_INPUTS(N), .GAMMA_CYCLE_WIDTH(G)) u_dut (
      .clk(clk), .grst(grst), .en(en), .inputs(inputs),
      .out_times(out_times), .out_valid(out_valid),
      .out_ready(out_ready), .overrun(overrun)
   );

   // Reference model: every input vector seen in the current gamma is kept;
   // a channel's time is the index of its first high sample.
   bit              m_run;
   int              m_ph;
   logic [N-1:0]    m_samp [$];
   logic [N*TW-1:0] m_times;
   bit              m_vld;
   bit              m_ovr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N*TW-1:0] decode();
      logic [N*TW-1:0] r;
      int t;
      r = '0;
      for (int i = 0; i < N; i++) begin
         t = G;
         for (int j = 0; j < m_samp.size(); j++) begin
            if (m_samp[j][i]) begin
               t = j;
               break;
            end
         end
         r[i*TW +: TW] = t[TW-1:0];
      end
      return r;
   endfunction

   task automatic model_reset();
      m_run = 0;
      m_ph  = 0;
      m_samp.delete();
      m_times = {N{5'd16}};
      m_vld = 0;
      m_ovr = 0;
   endtask

   // Advance model and DUT by one clock edge using the currently driven inputs.
   task automatic step();
      bit comp;
      logic [N*TW-1:0] res;
      comp = 0;
      res  = '0;
      if (m_run) begin
         if (!en) begin
            m_run = 0;
            m_ph  = 0;
            m_samp.delete();
         end else begin
            m_samp.push_back(inputs);
            if (m_ph == G-1) begin
               res  = decode();
               comp = 1;
               m_samp.delete();
               m_ph = 0;
            end else begin
               m_ph++;
            end
         end
      end else if (en) begin
         m_run = 1;
      end
      if (comp) begin
         if (!m_vld || out_ready) begin
            m_times = res;
            m_vld   = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (m_vld && out_ready) begin
         m_vld = 0;
      end
      @(posedge clk);
      #2;
      chk("valid", out_valid, m_vld);
      chk("overrun", overrun, m_ovr);
      chk("times", out_times, m_times);
   endtask

   // Asserts reset between edges and checks the outputs clear before any clock edge.
   task automatic pulse_reset();
      @(posedge clk);
      #3 grst = 1;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_times", out_times, {N{5'd16}});
      model_reset();
      @(posedge clk);
      #2 grst = 0;
   endtask

   initial begin
      #1ms;
      bad++;
      $display("FAIL watchdog: got=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      grst = 0; en = 0; out_ready = 0; inputs = '0;
      model_reset();
      pulse_reset();

      // First-edge decode with rises at 3, 0, 15 and none
      en = 1; out_ready = 1;
      step();
      for (int k = 0; k < G; k++) begin
         inputs = {1'b0, m_ph >= 15, 1'b1, m_ph >= 3};
         if (k == G-1) chk("r029_pre_valid", out_valid, 0);
         step();
      end
      chk("r029_valid", out_valid, 1);
      chk("r029_times", out_times, {5'd16, 5'd15, 5'd0, 5'd3});

      // Only the first rise of ch0 counts
      for (int k = 0; k < G; k++) begin
         inputs = {3'b000, (m_ph >= 2 && m_ph <= 4) || m_ph == 9};
         step();
      end
      chk("r030_ch0", out_times[4:0], 2);

      // Stalled consumer: second result dropped
      for (int k = 0; k < G; k++) begin
         out_ready = (k == 0);
         for (int i = 0; i < N; i++) inputs[i] = (m_ph >= i*3 + 1);
         step();
      end
      chk("r031_first_valid", out_valid, 1);
      for (int k = 0; k < G; k++) begin
         inputs = 4'hF;
         step();
      end
      chk("r031_keep", out_times, {5'd10, 5'd7, 5'd4, 5'd1});
      chk("r031_overrun", overrun, 1);
      out_ready = 1;
      step();
      chk("r031_drop", out_valid, 0);

      // Accept on the exact completion edge of the second gamma
      pulse_reset();
      out_ready = 0;
      step();
      for (int k = 0; k < G; k++) begin
         for (int i = 0; i < N; i++) inputs[i] = (m_ph >= i + 5);
         step();
      end
      for (int k = 0; k < G; k++) begin
         for (int i = 0; i < N; i++) inputs[i] = (m_ph >= 12 - i);
         out_ready = (m_ph == G-1);
         step();
      end
      chk("r032_valid", out_valid, 1);
      chk("r032_times", out_times, {5'd9, 5'd10, 5'd11, 5'd12});
      chk("r032_overrun", overrun, 0);

      // Abort at ph=7, then an independent gamma
      out_ready = 1;
      inputs = '0;
      step();
      while (m_ph < 7) begin
         inputs = {2'b00, m_ph >= 5, 1'b0};
         step();
      end
      en = 0;
      step();
      inputs = '0;
      for (int k = 0; k < 3; k++) step();
      chk("r033_no_result", out_valid, 0);
      en = 1;
      step();
      for (int k = 0; k < G; k++) begin
         inputs = {m_ph >= 2, 3'b000};
         step();
      end
      chk("r033_valid", out_valid, 1);
      chk("r033_times", out_times, {5'd2, 5'd16, 5'd16, 5'd16});

      // Asynchronous reset mid-gamma with a held result and overrun set
      out_ready = 0;
      for (int k = 0; k < 2*G + 5; k++) begin
         inputs = N'($urandom);
         step();
      end
      chk("r034_pre_valid", out_valid, 1);
      chk("r034_pre_overrun", overrun, 1);
      pulse_reset();

      // Random traffic
      for (int k = 0; k < 1500; k++) begin
         en = ($urandom_range(0, 40) != 0);
         for (int i = 0; i < N; i++) inputs[i] = ($urandom_range(0, 11) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 500) == 0) pulse_reset();
         else step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tdec_t_b.md
TDEC_T_B -- requirements
Module: tdec_t_b

Interface
REQ-001 Parameter NUM_INPUTS, default 4: number of temporal input channels decoded in parallel.
REQ-002 Parameter GAMMA_CYCLE_WIDTH, default 16: gamma-cycle length in clock cycles; SHALL be >= 2.
REQ-003 Derived constant TW = clog2(GAMMA_CYCLE_WIDTH+1): width of one decoded time; code GAMMA_CYCLE_WIDTH means "no edge" (infinity).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 grst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  decode enable; 0 holds block idle.
REQ-007 inputs  input  NUM_INPUTS  temporal (rising-edge-coded) signals, synchronous to clk.
REQ-008 out_times  output  NUM_INPUTS*TW  decoded times; channel i in bits [i*TW +: TW].
REQ-009 out_valid  output  1  out_times holds an unaccepted gamma-cycle result.
REQ-010 out_ready  input  1  consumer accepts out_times when out_valid && out_ready at a clock edge.
REQ-011 overrun  output  1  sticky: a completed result was dropped.

Function
REQ-012 State machine: IDLE and RUN; IDLE -> RUN on edge with en=1; RUN -> IDLE on edge with en=0.
REQ-013 Phase counter ph (0..GAMMA_CYCLE_WIDTH-1): 0 in IDLE; in RUN increments each cycle, wraps G-1 -> 0; first RUN cycle has ph=0.
REQ-014 Per-channel capture reg cap[i] (TW bits) and flag got[i]; both cleared (cap=G, got=0) in IDLE and on the edge leaving ph=G-1.
REQ-015 In RUN, if inputs[i]==1 and got[i]==0 at a cycle with phase ph, then cap[i]<=ph and got[i]<=1 at that edge; later activity on inputs[i] in the same gamma cycle is ignored.
REQ-016 An input already high at ph=0 decodes to 0; an input never high during the gamma cycle decodes to G.
REQ-017 Input high at ph=G-1 SHALL be captured as G-1 in that same cycle's result (final value includes the ph=G-1 sample combinationally merged into the transfer).
REQ-018 Completion: at edge leaving ph=G-1 in RUN, result is offered to output register; latency from gamma end to out_valid=1 is exactly 1 edge.
REQ-019 Handshake: if output register empty (out_valid=0) or being accepted this edge (out_valid && out_ready), result loads and out_valid=1.
REQ-020 If out_valid=1 and out_ready=0 at completion edge, new result is dropped, out_times unchanged, overrun<=1.
REQ-021 Acceptance without a simultaneous completion clears out_valid at that edge.
REQ-022 out_times and out_valid SHALL be stable while out_valid && !out_ready.
REQ-023 en deasserted mid-gamma: partial capture discarded, no result produced; pending output register and out_valid unaffected.
REQ-024 overrun clears only on grst.
REQ-025 No combinational path from inputs to any output; out_ready affects outputs only at clock edges.

Reset
REQ-026 On grst=1 asynchronously: state=IDLE, ph=0, cap[i]=G, got[i]=0, out_times all channels=G, out_valid=0, overrun=0.
REQ-027 After grst deassertion, first RUN cycle (if en=1) starts a fresh gamma cycle at ph=0.
REQ-028 grst asserted mid-gamma or with out_valid=1 discards all state; no result emitted.

Verification (N=4, G=16, TW=5)
REQ-029 en=1, out_ready=1; inputs rise at ph 3,0,15 and never on ch3 -> one edge after ph=15, out_valid=1, times {ch0=3,ch1=0,ch2=15,ch3=16}.
REQ-030 ch0 pulses high at ph 2-4, then again at ph 9 -> ch0 decodes 2 (first edge only).
REQ-031 out_ready=0 across two gamma cycles with distinct inputs -> out_times keep first result, overrun=1; out_ready=1 then -> out_valid drops next edge.
REQ-032 out_ready asserted on exact completion edge of second gamma -> first accepted, second loaded, out_valid stays 1, overrun=0.
REQ-033 en dropped at ph=7 after ch1 edge at ph=5, re-raised later -> no result for aborted cycle; next gamma decodes independently from ph=0.
REQ-034 grst pulsed asynchronously mid-cycle with out_valid=1 -> out_valid=0, overrun=0, all out_times=16 immediately, before next clk edge.
